// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if
//   Lamp-side bundle between the traffic-light controller and its passive monitor.
//   master: the controller side. It drives the lamp enables and Clear, and observes the status.
//   slave : the monitor (traffic_light_monitor). It samples the lamps and drives the status and faults.
// Signals
//   GREEN_EN/YELLOW_EN/RED_EN  lamp enables (same clock domain as the monitor)
//   Clear                      1-cycle pulse that clears the sticky faults and fault_code
//   phase[1:0]                 0 DARK, 1 GREEN, 2 YELLOW, 3 RED
//   phase_cycles/last_dur      phase timer and the duration of the last exited phase
//   cycle_done                 1-cycle pulse when a full legal G->Y->R->G cycle completes
//   fault_*/fault_code         sticky fault flags and the first-fault code
//   full_cycles[15:0]          completed-cycle counter (tied to 0 unless stats are built in)
interface traffic_light_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             GREEN_EN;
  logic             YELLOW_EN;
  logic             RED_EN;
  logic             Clear;
  logic [1:0]       phase;
  logic [CNT_W-1:0] phase_cycles;
  logic [CNT_W-1:0] last_dur;
  logic             cycle_done;
  logic             fault_seq;
  logic             fault_multi;
  logic             fault_short;
  logic             fault_long;
  logic [2:0]       fault_code;
  logic [15:0]      full_cycles;

  modport master (
    output GREEN_EN, YELLOW_EN, RED_EN, Clear,
    input  phase, phase_cycles, last_dur, cycle_done,
    input  fault_seq, fault_multi, fault_short, fault_long, fault_code, full_cycles
  );

  modport slave (
    input  GREEN_EN, YELLOW_EN, RED_EN, Clear,
    output phase, phase_cycles, last_dur, cycle_done,
    output fault_seq, fault_multi, fault_short, fault_long, fault_code, full_cycles
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker and decoder on the lamp side of a traffic-light controller. It samples
//   the lamp enables once and decodes them into a phase. It times each phase. It flags the
//   following faults in sticky bits:
//     - illegal phase sequences
//     - lamp overlaps
//     - phases that end too early
//     - phases that are held too long
//   It also reports the first fault since the last Clear.
// Ports
//   Clk      system clock
//   Reset_n  asynchronous active-low reset; every output and all state go to 0 at once
//   mon      traffic_light_monitor_if.slave. It carries these signals:
//              - inputs: the lamp enables and Clear
//              - outputs: phase, the timers, cycle_done, the faults and full_cycles
// Build option
//   TL_MON_STATS_EN  when defined, full_cycles counts cycle_done pulses and wraps.
//                    When not defined, full_cycles is tied to 0.
// Timing
//   The lamps are registered once, and the phase updates on the following edge, so phase
//   lags the lamp inputs by two clocks. Every output comes straight from a register.
module traffic_light_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned GREEN_MIN  = 170000000,
  parameter int unsigned GREEN_MAX  = 190000000,
  parameter int unsigned YELLOW_MIN = 55000000,
  parameter int unsigned YELLOW_MAX = 65000000,
  parameter int unsigned RED_MIN    = 65000000,
  parameter int unsigned RED_MAX    = 75000000
) (
  input logic                    Clk,
  input logic                    Reset_n,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    StDark   = 2'd0,
    StGreen  = 2'd1,
    StYellow = 2'd2,
    StRed    = 2'd3
  } phase_e;

  localparam logic [2:0] CodeNone  = 3'd0;
  localparam logic [2:0] CodeSeq   = 3'd1;
  localparam logic [2:0] CodeMulti = 3'd2;
  localparam logic [2:0] CodeShort = 3'd3;
  localparam logic [2:0] CodeLong  = 3'd4;

  localparam logic [CNT_W-1:0] GreenMin  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GreenMax  = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YellowMin = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] YellowMax = CNT_W'(YELLOW_MAX);
  localparam logic [CNT_W-1:0] RedMin    = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] RedMax    = CNT_W'(RED_MAX);

  // Sampled lamps in {G, Y, R} order.
  logic [2:0]       s_lamps_q;
  phase_e           phase_q;
  phase_e           lamp_phase;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] cycles_inc;
  logic [CNT_W-1:0] last_dur_q;
  logic [CNT_W-1:0] p_min;
  logic [CNT_W-1:0] p_max;

  logic multi;
  logic change;
  logic legal;
  logic timed;

  logic det_seq;
  logic det_multi;
  logic det_short;
  logic det_long;

  logic       fault_seq_q, fault_seq_d;
  logic       fault_multi_q, fault_multi_d;
  logic       fault_short_q, fault_short_d;
  logic       fault_long_q, fault_long_d;
  logic [2:0] fault_code_q, fault_code_d;
  logic [2:0] code_base;

  logic cycle_done_q, cycle_done_d;
  // These flags track legal G->Y and Y->R steps since the last GREEN entry. Every phase
  // change overwrites them, so a cycle counts only when its steps are contiguous.
  logic got_y_q, got_y_d;
  logic got_r_q, got_r_d;

  // Decode the lamps, check the transition and pick the timing limits for the current phase.
  always_comb begin
    multi = (s_lamps_q[2] & s_lamps_q[1]) | (s_lamps_q[2] & s_lamps_q[0]) |
            (s_lamps_q[1] & s_lamps_q[0]);

    // Overlapping patterns fall through to the default: the phase holds.
    lamp_phase = phase_q;
    case (s_lamps_q)
      3'b000:  lamp_phase = StDark;
      3'b100:  lamp_phase = StGreen;
      3'b010:  lamp_phase = StYellow;
      3'b001:  lamp_phase = StRed;
      default: lamp_phase = phase_q;
    endcase

    change = !multi && (lamp_phase != phase_q);

    // The timer saturates at all-ones and never wraps.
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

    legal = 1'b0;
    unique case (phase_q)
      StDark:   legal = (lamp_phase == StGreen);
      StGreen:  legal = (lamp_phase == StYellow);
      StYellow: legal = (lamp_phase == StRed);
      StRed:    legal = (lamp_phase == StGreen);
    endcase
    // An abort to DARK is always legal.
    legal = legal | (lamp_phase == StDark);

    p_min = '0;
    p_max = '1;
    unique case (phase_q)
      StGreen: begin
        p_min = GreenMin;
        p_max = GreenMax;
      end
      StYellow: begin
        p_min = YellowMin;
        p_max = YellowMax;
      end
      StRed: begin
        p_min = RedMin;
        p_max = RedMax;
      end
      default: ;
    endcase
    timed = (phase_q != StDark);
  end

  // Detect faults and compute the next sticky fault state.
  always_comb begin
    det_seq   = change && !legal;
    det_multi = multi;
    // cycles_inc is the duration that will be reported for the phase being left.
    det_short = change && timed && (lamp_phase != StDark) && (cycles_inc < p_min);
    // This fires once, on the edge where the timer reaches P_MAX. The second term stops
    // it from firing again while the timer sits saturated at P_MAX.
    det_long  = !change && timed && (cycles_inc == p_max) && (cycles_q != p_max);

    // Clear drops the old state, but a fault found in the same cycle still sets its bit.
    fault_seq_d   = (fault_seq_q   & ~mon.Clear) | det_seq;
    fault_multi_d = (fault_multi_q & ~mon.Clear) | det_multi;
    fault_short_d = (fault_short_q & ~mon.Clear) | det_short;
    fault_long_d  = (fault_long_q  & ~mon.Clear) | det_long;

    code_base    = mon.Clear ? CodeNone : fault_code_q;
    fault_code_d = code_base;
    if (code_base == CodeNone) begin
      if (det_seq) begin
        fault_code_d = CodeSeq;
      end else if (det_multi) begin
        fault_code_d = CodeMulti;
      end else if (det_short) begin
        fault_code_d = CodeShort;
      end else if (det_long) begin
        fault_code_d = CodeLong;
      end
    end

    got_y_d      = got_y_q;
    got_r_d      = got_r_q;
    cycle_done_d = 1'b0;
    if (change) begin
      got_y_d      = (phase_q == StGreen) && (lamp_phase == StYellow);
      got_r_d      = (phase_q == StYellow) && (lamp_phase == StRed) && got_y_q;
      cycle_done_d = (phase_q == StRed) && (lamp_phase == StGreen) && got_r_q;
    end
  end

  // FSM state, timers and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s_lamps_q     <= 3'b000;
      phase_q       <= StDark;
      cycles_q      <= '0;
      last_dur_q    <= '0;
      cycle_done_q  <= 1'b0;
      got_y_q       <= 1'b0;
      got_r_q       <= 1'b0;
      fault_seq_q   <= 1'b0;
      fault_multi_q <= 1'b0;
      fault_short_q <= 1'b0;
      fault_long_q  <= 1'b0;
      fault_code_q  <= CodeNone;
    end else begin
      s_lamps_q <= {mon.GREEN_EN, mon.YELLOW_EN, mon.RED_EN};
      if (change) begin
        phase_q    <= lamp_phase;
        cycles_q   <= '0;
        last_dur_q <= cycles_inc;
      end else begin
        cycles_q <= cycles_inc;
      end
      cycle_done_q  <= cycle_done_d;
      got_y_q       <= got_y_d;
      got_r_q       <= got_r_d;
      fault_seq_q   <= fault_seq_d;
      fault_multi_q <= fault_multi_d;
      fault_short_q <= fault_short_d;
      fault_long_q  <= fault_long_d;
      fault_code_q  <= fault_code_d;
    end
  end

`ifdef TL_MON_STATS_EN
  logic [15:0] full_cycles_q;

  // Clear does not affect this counter. It wraps from 0xFFFF to 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      full_cycles_q <= 16'h0;
    end else if (cycle_done_d) begin
      full_cycles_q <= full_cycles_q + 16'd1;
    end
  end

  assign mon.full_cycles = full_cycles_q;
`else
  assign mon.full_cycles = 16'h0;
`endif

  assign mon.phase        = phase_q;
  assign mon.phase_cycles = cycles_q;
  assign mon.last_dur     = last_dur_q;
  assign mon.cycle_done   = cycle_done_q;
  assign mon.fault_seq    = fault_seq_q;
  assign mon.fault_multi  = fault_multi_q;
  assign mon.fault_short  = fault_short_q;
  assign mon.fault_long   = fault_long_q;
  assign mon.fault_code   = fault_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor. Limits: GREEN 8/12, YELLOW 3/5, RED 5/7.
// The stimulus pushes one expected record for each phase entry and for each probe of a
// steady phase. The monitor pops a record whenever the DUT phase changes or a probe is
// pending. Lamps and Clear are driven on the falling edge. Outputs are sampled 2 ns after
// each rising edge and 2 ns after the reset falls.
module tb_traffic_light_monitor;

`ifdef TL_MON_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  localparam logic [1:0] PD = 2'd0;
  localparam logic [1:0] PG = 2'd1;
  localparam logic [1:0] PY = 2'd2;
  localparam logic [1:0] PR = 2'd3;
  localparam logic [2:0] LD = 3'b000;
  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;
  // Fault vector order: {seq, multi, short, long}.
  localparam logic [3:0] FNone  = 4'b0000;
  localparam logic [3:0] FSeq   = 4'b1000;
  localparam logic [3:0] FMulti = 4'b0100;
  localparam logic [3:0] FShort = 4'b0010;
  localparam logic [3:0] FLong  = 4'b0001;

  typedef struct {
    int          tag;
    logic [1:0]  ph;
    int unsigned cyc;
    int unsigned dur;
    bit          dur_chk;
    bit          done;
    logic [3:0]  f;
    logic [2:0]  code;
    int unsigned fc;
  } rec_t;

  logic Clk;
  logic Reset_n;
  traffic_light_monitor_if #(.CNT_W(32)) mon ();

  traffic_light_monitor #(
    .CNT_W     (32),
    .GREEN_MIN (8),
    .GREEN_MAX (12),
    .YELLOW_MIN(3),
    .YELLOW_MAX(5),
    .RED_MIN   (5),
    .RED_MAX   (7)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .mon    (mon)
  );

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n = 0;
  int   probe_req = 0;
  int   probe_ack = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int unsigned fcx(input int unsigned n);
    return Stats ? n : 0;
  endfunction

  function automatic void chk(input int tag, input string what, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL rec%0d %s: got %0d expected %0d", tag, what, act, req);
    end
  endfunction

  task automatic expect_rec(input logic [1:0] ph, input int unsigned cyc,
                            input int unsigned dur, input bit dur_chk, input bit done,
                            input logic [3:0] f, input logic [2:0] code,
                            input int unsigned fc);
    rec_t r;
    r.tag = tag_n;
    r.ph = ph;
    r.cyc = cyc;
    r.dur = dur;
    r.dur_chk = dur_chk;
    r.done = done;
    r.f = f;
    r.code = code;
    r.fc = fc;
    tag_n++;
    exp_q.push_back(r);
  endtask

  // Probe of a steady phase: the record is checked after the next rising edge.
  task automatic probe(input logic [1:0] ph, input int unsigned cyc, input int unsigned dur,
                       input logic [3:0] f, input logic [2:0] code, input int unsigned fc);
    expect_rec(ph, cyc, dur, 1'b1, 1'b0, f, code, fc);
    probe_req++;
  endtask

  // Start from a falling edge: lamps stay stable for exactly n rising edges.
  task automatic hold(input logic [2:0] l, input int n);
    mon.GREEN_EN  = l[2];
    mon.YELLOW_EN = l[1];
    mon.RED_EN    = l[0];
    repeat (n) @(negedge Clk);
  endtask

  // Monitor
  always begin
    logic [1:0] cur;
    logic [1:0] last_ph;
    rec_t       r;
    @(posedge Clk or negedge Reset_n);
    #2;
    cur = mon.phase;
    if (cur !== last_ph || probe_req != probe_ack) begin
      if (probe_req != probe_ack) probe_ack++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: phase %0d cycles %0d with no expected record",
                 cur, mon.phase_cycles);
      end else begin
        r = exp_q.pop_front();
        chk(r.tag, "phase", 32'(mon.phase), 32'(r.ph));
        chk(r.tag, "phase_cycles", mon.phase_cycles, r.cyc);
        if (r.dur_chk) chk(r.tag, "last_dur", mon.last_dur, r.dur);
        chk(r.tag, "cycle_done", 32'(mon.cycle_done), 32'(r.done));
        chk(r.tag, "faults{seq,multi,short,long}",
            32'({mon.fault_seq, mon.fault_multi, mon.fault_short, mon.fault_long}),
            32'(r.f));
        chk(r.tag, "fault_code", 32'(mon.fault_code), 32'(r.code));
        chk(r.tag, "full_cycles", 32'(mon.full_cycles), r.fc);
      end
    end else begin
      chk(-1, "idle_cycle_done", 32'(mon.cycle_done), 32'd0);
    end
    last_ph = cur;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    Reset_n       = 1'b0;
    mon.GREEN_EN  = 1'b0;
    mon.YELLOW_EN = 1'b0;
    mon.RED_EN    = 1'b0;
    mon.Clear     = 1'b0;
    @(negedge Clk);
    probe(PD, 0, 0, FNone, 3'd0, 0);  // reset state
    @(negedge Clk);
    Reset_n = 1'b1;

    // Legal G10 Y4 R6 and back to G: one completed cycle, no faults.
    hold(LD, 3);
    expect_rec(PG, 0, 0, 1'b0, 1'b0, FNone, 3'd0, 0);
    hold(LG, 10);
    expect_rec(PY, 0, 10, 1'b1, 1'b0, FNone, 3'd0, 0);
    hold(LY, 4);
    expect_rec(PR, 0, 4, 1'b1, 1'b0, FNone, 3'd0, 0);
    hold(LR, 6);
    expect_rec(PG, 0, 6, 1'b1, 1'b1, FNone, 3'd0, fcx(1));
    hold(LG, 5);
    // G5 then R: this is both short and a bad sequence. The sequence fault has the lowest code.
    expect_rec(PR, 0, 5, 1'b1, 1'b0, FSeq | FShort, 3'd1, fcx(1));
    hold(LR, 4);
    mon.Clear = 1'b1;
    hold(LR, 1);
    mon.Clear = 1'b0;
    probe(PR, 4, 5, FNone, 3'd0, fcx(1));
    hold(LR, 1);
    // R->G is legal, but the cycle was broken earlier, so there is no pulse.
    expect_rec(PG, 0, 6, 1'b1, 1'b0, FNone, 3'd0, fcx(1));
    hold(LG, 3);
    hold(3'b110, 1);
    probe(PG, 3, 6, FMulti, 3'd2, fcx(1));  // phase holds and the timer keeps counting
    hold(LG, 2);
    mon.Clear = 1'b1;
    probe(PG, 5, 6, FNone, 3'd0, fcx(1));
    hold(LG, 1);
    mon.Clear = 1'b0;
    hold(LG, 5);
    probe(PG, 11, 6, FNone, 3'd0, fcx(1));  // one short of GREEN_MAX
    hold(LG, 1);
    probe(PG, 12, 6, FLong, 3'd4, fcx(1));
    hold(LG, 1);
    hold(3'b101, 1);
    mon.Clear = 1'b1;  // lands on the same edge as the multi-lamp detection
    probe(PG, 14, 6, FMulti, 3'd2, fcx(1));
    hold(LG, 1);
    mon.Clear = 1'b0;
    hold(LG, 4);
    expect_rec(PD, 0, 20, 1'b1, 1'b0, FMulti, 3'd2, fcx(1));
    hold(LD, 3);
    mon.Clear = 1'b1;
    probe(PD, 2, 20, FNone, 3'd0, fcx(1));
    hold(LD, 1);
    mon.Clear = 1'b0;

    // G9, a short Y2, then R; the reset arrives mid-period during R.
    expect_rec(PG, 0, 4, 1'b1, 1'b0, FNone, 3'd0, fcx(1));
    hold(LG, 9);
    expect_rec(PY, 0, 9, 1'b1, 1'b0, FNone, 3'd0, fcx(1));
    hold(LY, 2);
    expect_rec(PR, 0, 2, 1'b1, 1'b0, FShort, 3'd3, fcx(1));
    hold(LR, 3);
    expect_rec(PD, 0, 0, 1'b1, 1'b0, FNone, 3'd0, 0);
    #1 Reset_n = 1'b0;
    mon.GREEN_EN  = 1'b0;
    mon.YELLOW_EN = 1'b0;
    mon.RED_EN    = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Three legal cycles after reset.
    hold(LD, 2);
    for (int i = 0; i < 3; i++) begin
      expect_rec(PG, 0, 6, i > 0, i > 0, FNone, 3'd0, fcx(i));
      hold(LG, 9);
      expect_rec(PY, 0, 9, 1'b1, 1'b0, FNone, 3'd0, fcx(i));
      hold(LY, 4);
      expect_rec(PR, 0, 4, 1'b1, 1'b0, FNone, 3'd0, fcx(i));
      hold(LR, 6);
    end
    expect_rec(PG, 0, 6, 1'b1, 1'b1, FNone, 3'd0, fcx(3));
    hold(LG, 3);
    expect_rec(PD, 0, 3, 1'b1, 1'b0, FNone, 3'd0, fcx(3));
    hold(LD, 3);
    repeat (3) @(negedge Clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_records: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
